serial_subtractor: RTL and testbench



---
 rtl/sersub_pkg.sv | 14 +
 rtl/fs_bit_cell.sv | 17 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_bit_cell.sv
// Single-bit full subtractor: d = ai - bi - br, bnext = borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: ai/bi minuend/subtrahend bits, br borrow-in -> d difference bit, bnext borrow-out.
module fs_bit_cell (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic d,
    output logic bnext
);

    assign d     = ai ^ bi ^ br;
    // Borrow when ai=0,bi=1, or when the bits are equal and a borrow is pending.
    assign bnext = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first through one fs_bit_cell.
// Latency: start sampled in IDLE -> WIDTH SHIFT cycles (busy) -> one DONE cycle (done pulse).
// Backpressure: none; start is ignored (not queued) while busy or in DONE.
// Ports: clk, rst (sync, active-high); start/a/b/bin request; busy, done, diff, bout results.
// Optional: define SERSUB_OVF_EN to add output ovf (signed overflow, registered with diff).
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits already produced; the current cell output
    // supplies the MSB, so the full result is {d, res_sh}.
    logic [WIDTH-2:0] res_sh;
    logic             br_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] res_nxt;

    fs_bit_cell u_cell (
        .ai    (a_sh[0]),
        .bi    (b_sh[0]),
        .br    (br_q),
        .d     (d),
        .bnext (bnext)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign res_nxt  = {d, res_sh};

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br_q   <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br_q <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt[WIDTH-1:1];
                    br_q   <= bnext;
                    cnt    <= cnt + 1'b1;
                    // Results are published only on the final step, so the
                    // outputs hold the previous result while shifting.
                    if (last_bit) begin
                        diff <= res_nxt;
                        bout <= bnext;
`ifdef SERSUB_OVF_EN
                        // On the final step the cell sees the operand MSBs.
                        ovf  <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERSUB_OVF_EN
    logic       ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        int         exp_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops one expectation per done pulse and checks width/latency.
    logic prev_done = 1'b0;
    int   busy_run  = 0;
    exp_t m_e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk("done_width", {31'd0, prev_done}, 32'd0);
                chk("busy_cycles", busy_run, WIDTH);
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: done=1 with no operation pending, expected 0 (cycle %0d)", cyc);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("diff", {24'd0, diff}, {24'd0, m_e.diff});
                    chk("bout", {31'd0, bout}, {31'd0, m_e.bout});
`ifdef SERSUB_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, m_e.ovf});
`endif
                    chk("latency", cyc, m_e.exp_cyc);
                end
            end
            if (busy === 1'b1) busy_run++;
            else if (done !== 1'b1) busy_run = 0;
            prev_done = done;
        end
    end

    // Called at a negedge; returns at a negedge where the DUT is in IDLE.
    task automatic wait_idle();
        int k = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_total++;
            $display("FAIL idle_timeout: busy=%0b done=%0b, expected idle within 100 cycles", busy, done);
        end
    endtask

    // Issue one operation; start stays high for 'hold' cycles, then operands are scrambled.
    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                      input logic [7:0] ediff, input logic ebout, input logic eovf,
                      input bit push, input int hold);
        wait_idle();
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        if (push) sb_q.push_back('{ediff, ebout, eovf, cyc + WIDTH + 1});
        repeat (hold) @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
    endtask

    initial begin : driver
        logic [8:0] r;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        int         k;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERSUB_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Directed vectors, hand-computed.
        op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b1, 1);
        op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1);
        op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1, 1);
        // start held through the whole busy phase: must yield exactly one result.
        op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, WIDTH + 1);
        repeat (WIDTH + 3) @(negedge clk);
        chk("held_start_single", sb_q.size(), 0);

        // Reset in the 4th SHIFT cycle aborts with no done pulse.
        op(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_bout", {31'd0, bout}, 32'd0);
`ifdef SERSUB_OVF_EN
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
        op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            r    = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            op(ra, rb, rbin, r[7:0], r[8], (ra[7] ^ rb[7]) & (r[7] ^ ra[7]), 1'b1, 1);
        end

        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drained", sb_q.size(), 0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
